// File: rtl/frame_send_pkg.sv
// Shared definitions for the frame sender and the matching receiver.
// Holds the default sync word, the FSM state encoding, the header field
// positions, the legal payload size limits and small helpers that build and
// validate headers.
package frame_send_pkg;

    localparam logic [63:0] SYNC_WORD = 64'h0000_0000_1acf_fc1d;

    localparam int unsigned BeatBytes = 32;
    localparam int unsigned NumLanes  = 8;

    // Header field positions inside the 256-bit header beat
    localparam int unsigned HdrCntMsb  = 247;
    localparam int unsigned HdrCntLsb  = 240;
    localparam int unsigned HdrSizeMsb = 223;
    localparam int unsigned HdrSizeLsb = 208;
    localparam int unsigned HdrSyncMsb = 191;
    localparam int unsigned HdrSyncLsb = 128;

    // Payload size limits in bytes; sizes must also be a multiple of BeatBytes
    localparam logic [15:0] SizeMin = 16'd64;
    localparam logic [15:0] SizeMax = 16'd65504;

    typedef enum logic [1:0] {
        StIdle,
        StHdr,
        StData,
        StGap
    } state_e;

    function automatic logic size_legal(input logic [15:0] size);
        return (size[4:0] == 5'd0) && (size >= SizeMin) && (size <= SizeMax);
    endfunction

    function automatic logic [255:0] build_header(input logic [7:0]  cnt,
                                                  input logic [15:0] size,
                                                  input logic [63:0] sync);
        logic [255:0] hdr;
        hdr = '0;
        hdr[HdrCntMsb:HdrCntLsb]   = cnt;
        hdr[HdrSizeMsb:HdrSizeLsb] = size;
        hdr[HdrSyncMsb:HdrSyncLsb] = sync;
        return hdr;
    endfunction

endpackage

// File: rtl/frame_pattern_gen.sv
// Payload pattern generator (combinational).
// Each 32-bit lane j of a payload beat carries {frame_cnt, beat, j}.
// Ports:
//   frame_cnt - number of the frame being sent
//   beat      - payload beat index k
//   data      - 256-bit payload beat
module frame_pattern_gen
    import frame_send_pkg::*;
(
    input  logic [7:0]   frame_cnt,
    input  logic [15:0]  beat,
    output logic [255:0] data
);

    always_comb begin
        data = '0;
        for (int j = 0; j < int'(NumLanes); j++) begin
            data[32*j +: 32] = {frame_cnt, beat, 8'(j)};
        end
    end

endmodule

// File: rtl/frame_send.sv
// Frame sender towards an Aurora TX AXI4-Stream user interface.
// A frame is one header beat followed by frame_size/32+1 payload beats, then
// GAP_MIN idle cycles. All outputs are registered.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   start       - one-cycle send request, honoured only when idle
//   frame_size  - payload bytes, sampled when start is accepted
//   tready      - downstream can accept a beat
//   tvalid/tdata/tlast - AXI4-Stream beat
//   busy        - not idle
//   frame_cnt   - frames sent, modulo 256
//   size_err    - one-cycle pulse for a start with an illegal frame_size
module frame_send
    import frame_send_pkg::*;
#(
    parameter int unsigned DW        = 256,  // only 256 is supported
    parameter logic [63:0] SYNC_WORD = frame_send_pkg::SYNC_WORD,
    parameter int unsigned GAP_MIN   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [15:0]   frame_size,
    input  logic          tready,
    output logic          tvalid,
    output logic [DW-1:0] tdata,
    output logic          tlast,
    output logic          busy,
    output logic [7:0]    frame_cnt,
    output logic          size_err
);

    state_e        state_q;
    logic [15:0]   beat_q;
    logic [10:0]   last_beat_q;  // frame_size/32, index of the final payload beat
    logic [15:0]   gap_q;
    logic [7:0]    frame_cnt_q;
    logic          tvalid_q;
    logic [DW-1:0] tdata_q;
    logic          tlast_q;
    logic          busy_q;
    logic          size_err_q;

    logic [15:0]   beat_nxt;
    logic [255:0]  pattern;

    // Index of the payload beat to present after the current transfer
    assign beat_nxt = (state_q == StHdr) ? 16'd0 : beat_q + 16'd1;

    frame_pattern_gen u_pattern_gen (
        .frame_cnt (frame_cnt_q),
        .beat      (beat_nxt),
        .data      (pattern)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            beat_q      <= '0;
            last_beat_q <= '0;
            gap_q       <= '0;
            frame_cnt_q <= '0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            tlast_q     <= 1'b0;
            busy_q      <= 1'b0;
            size_err_q  <= 1'b0;
        end else begin
            size_err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (size_legal(frame_size)) begin
                            state_q     <= StHdr;
                            last_beat_q <= frame_size[15:5];
                            beat_q      <= '0;
                            busy_q      <= 1'b1;
                            tvalid_q    <= 1'b1;
                            tlast_q     <= 1'b0;
                            tdata_q     <= build_header(frame_cnt_q, frame_size, SYNC_WORD);
                        end else begin
                            size_err_q <= 1'b1;
                        end
                    end
                end
                StHdr: begin
                    if (tready) begin
                        state_q <= StData;
                        beat_q  <= beat_nxt;
                        tdata_q <= pattern;
                        tlast_q <= (beat_nxt == {5'd0, last_beat_q});
                    end
                end
                StData: begin
                    if (tready) begin
                        if (tlast_q) begin
                            state_q     <= StGap;
                            frame_cnt_q <= frame_cnt_q + 8'd1;
                            gap_q       <= '0;
                            tvalid_q    <= 1'b0;
                            tlast_q     <= 1'b0;
                            tdata_q     <= '0;
                        end else begin
                            beat_q  <= beat_nxt;
                            tdata_q <= pattern;
                            tlast_q <= (beat_nxt == {5'd0, last_beat_q});
                        end
                    end
                end
                StGap: begin
                    if (gap_q == 16'(GAP_MIN - 1)) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_q <= gap_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tvalid    = tvalid_q;
    assign tdata     = tdata_q;
    assign tlast     = tlast_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;
    assign size_err  = size_err_q;

endmodule

// File: tb/tb_frame_send.sv
// Self-checking bench for frame_send: a transaction-level model builds the
// expected beat list of every accepted frame and tracks idle/send/gap phases.
module tb_frame_send;

    localparam int          GapMin = 4;
    localparam logic [63:0] Sync   = 64'h0000_0000_1acf_fc1d;
    localparam int          PhIdle = 0;
    localparam int          PhSend = 1;
    localparam int          PhGap  = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [15:0]  frame_size;
    logic         tready;
    logic         tvalid;
    logic [255:0] tdata;
    logic         tlast;
    logic         busy;
    logic [7:0]   frame_cnt;
    logic         size_err;

    frame_send #(
        .DW        (256),
        .SYNC_WORD (Sync),
        .GAP_MIN   (GapMin)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .frame_size (frame_size),
        .tready     (tready),
        .tvalid     (tvalid),
        .tdata      (tdata),
        .tlast      (tlast),
        .busy       (busy),
        .frame_cnt  (frame_cnt),
        .size_err   (size_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model state
    int           m_phase;
    int           m_gap;
    logic [7:0]   m_cnt;
    int           accepted = 0;
    logic [255:0] exp_data[$];
    bit           exp_last[$];
    bit           exp_hdr[$];
    logic [7:0]   last_hdr_cnt = 8'hff;
    bit           meas_gap = 0;
    bit           gap_armed = 0;
    int           gap_run = 0;
    int           target;

    function automatic bit legal(input int size);
        return (size % 32 == 0) && (size >= 64) && (size <= 65504);
    endfunction

    task automatic model_reset();
        m_phase   = PhIdle;
        m_gap     = 0;
        m_cnt     = 8'd0;
        gap_armed = 0;
        exp_data.delete();
        exp_last.delete();
        exp_hdr.delete();
    endtask

    task automatic push_frame(input int size);
        logic [255:0] b;
        logic [15:0]  sz;
        sz = size[15:0];
        b = '0;
        b[247:240] = m_cnt;
        b[223:208] = sz;
        b[191:128] = Sync;
        exp_data.push_back(b);
        exp_last.push_back(1'b0);
        exp_hdr.push_back(1'b1);
        for (int k = 0; k <= size / 32; k++) begin
            for (int j = 0; j < 8; j++) b[32*j +: 32] = {m_cnt, 16'(k), 8'(j)};
            exp_data.push_back(b);
            exp_last.push_back(k == size / 32);
            exp_hdr.push_back(1'b0);
        end
    endtask

    // Advance one clock: update the model from the inputs and the beat on the
    // bus before the edge, then compare the DUT just after the edge.
    task automatic cycle();
        logic [255:0] pre_data;
        logic         pre_valid;
        logic         pre_last;
        bit           exp_err;
        pre_valid = tvalid;
        pre_last  = tlast;
        pre_data  = tdata;
        exp_err   = 0;
        if (rst) begin
            model_reset();
        end else begin
            if (pre_valid && tready && pre_last) begin
                gap_armed = 1;
                gap_run   = 0;
            end
            case (m_phase)
                PhIdle: begin
                    if (start) begin
                        if (legal(int'(frame_size))) begin
                            push_frame(int'(frame_size));
                            m_phase = PhSend;
                            accepted++;
                        end else begin
                            exp_err = 1;
                        end
                    end
                end
                PhSend: begin
                    if (tready && exp_data.size() > 0) begin
                        if (exp_hdr[0]) last_hdr_cnt = pre_data[247:240];
                        if (exp_last[0]) begin
                            m_cnt   = m_cnt + 8'd1;
                            m_phase = PhGap;
                            m_gap   = GapMin;
                        end
                        void'(exp_data.pop_front());
                        void'(exp_last.pop_front());
                        void'(exp_hdr.pop_front());
                    end
                end
                default: begin
                    m_gap--;
                    if (m_gap == 0) m_phase = PhIdle;
                end
            endcase
        end
        @(posedge clk);
        #1;
        check("tvalid", 256'(tvalid), 256'(m_phase == PhSend));
        check("busy", 256'(busy), 256'(m_phase != PhIdle));
        check("size_err", 256'(size_err), 256'(exp_err));
        check("frame_cnt", 256'(frame_cnt), 256'(m_cnt));
        if (m_phase == PhSend && exp_data.size() > 0) begin
            check("tdata", tdata, exp_data[0]);
            check("tlast", 256'(tlast), 256'(exp_last[0]));
        end else begin
            check("tlast_idle", 256'(tlast), 256'(0));
        end
        if (gap_armed) begin
            if (!tvalid) begin
                gap_run++;
            end else begin
                if (meas_gap) check("gap_len", 256'(gap_run), 256'(GapMin + 1));
                gap_armed = 0;
            end
        end
    endtask

    task automatic wait_idle(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (m_phase == PhIdle) break;
            cycle();
        end
        check("idle_timeout", 256'(m_phase == PhIdle), 256'(1));
    endtask

    initial begin
        int bad_sizes[6];
        bad_sizes = '{100, 0, 32, 65535, 65503, 97};
        rst        = 1'b1;
        start      = 1'b0;
        frame_size = 16'd0;
        tready     = 1'b0;
        model_reset();

        // Reset state
        repeat (2) cycle();
        check("rst_tdata", tdata, 256'(0));
        rst = 1'b0;

        // Single 64-byte frame, tready high
        tready     = 1'b1;
        frame_size = 16'd64;
        start      = 1'b1;
        cycle();
        start = 1'b0;
        repeat (12) cycle();

        // 96-byte frame with tready toggling every cycle
        frame_size = 16'd96;
        start      = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tready = (i % 2 == 1);
            cycle();
        end
        tready = 1'b1;
        wait_idle(20);

        // Illegal sizes
        foreach (bad_sizes[i]) begin
            frame_size = 16'(bad_sizes[i]);
            start      = 1'b1;
            cycle();
            start = 1'b0;
            cycle();
        end

        // Largest legal frame
        frame_size = 16'd65504;
        start      = 1'b1;
        cycle();
        start = 1'b0;
        wait_idle(2100);

        // start held high: back-to-back frames
        meas_gap   = 1;
        frame_size = 16'd64;
        target     = accepted + 3;
        for (int i = 0; i < 60; i++) begin
            start = (accepted < target);
            cycle();
        end
        start = 1'b0;
        wait_idle(20);
        meas_gap = 0;

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            start      = ($urandom_range(0, 9) == 0);
            frame_size = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                                     : 16'(64 + 32 * $urandom_range(0, 14));
            tready     = ($urandom_range(0, 3) != 0);
            cycle();
        end
        start  = 1'b0;
        tready = 1'b1;
        wait_idle(600);

        // Reset on the 3rd payload beat of a 128-byte frame
        frame_size = 16'd128;
        start      = 1'b1;
        cycle();
        start = 1'b0;
        repeat (3) cycle();
        check("s5_before_rst_tvalid", 256'(tvalid), 256'(1));
        #2;
        rst = 1'b1;
        #1;
        check("s5_async_tvalid", 256'(tvalid), 256'(0));
        check("s5_async_tlast", 256'(tlast), 256'(0));
        check("s5_async_busy", 256'(busy), 256'(0));
        check("s5_async_cnt", 256'(frame_cnt), 256'(0));
        cycle();
        rst        = 1'b0;
        frame_size = 16'd64;
        start      = 1'b1;
        cycle();
        start = 1'b0;
        check("s5_hdr_cnt", 256'(tdata[247:240]), 256'(0));
        wait_idle(20);

        // 257 frames of 64 bytes from a fresh reset
        rst = 1'b1;
        cycle();
        rst        = 1'b0;
        frame_size = 16'd64;
        tready     = 1'b1;
        target     = accepted + 257;
        for (int i = 0; i < 257 * 9 + 40; i++) begin
            start = (accepted < target);
            cycle();
            if (accepted >= target && m_phase == PhIdle) break;
        end
        start = 1'b0;
        wait_idle(20);
        check("s4_hdr257_cnt", 256'(last_hdr_cnt), 256'(0));
        check("s4_frame_cnt", 256'(frame_cnt), 256'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/frame_send.md
FRAME_SEND -- requirements
Module: frame_send

Interface
REQ-001 Parameter DW, default 256, meaning tdata width in bits; only 256 is supported.
REQ-002 Parameter SYNC_WORD, default 64'h0000_0000_1acf_fc1d, meaning the header sync word.
REQ-003 Parameter GAP_MIN, default 4, meaning the minimum number of idle cycles between frames.
REQ-004 Port clk, input, 1 bit, meaning the single clock for all logic.
REQ-005 Port rst, input, 1 bit, meaning reset; asynchronous, active-high.
REQ-006 Port start, input, 1 bit, meaning a one-cycle request to send one frame.
REQ-007 Port frame_size, input, 16 bits, meaning payload bytes; sampled only when start is accepted.
REQ-008 Port tready, input, 1 bit, meaning the downstream Aurora TX user interface can take a beat.
REQ-009 Port tvalid, output, 1 bit, meaning tdata holds a valid beat.
REQ-010 Port tdata, output, 256 bits, meaning the beat data.
REQ-011 Port tlast, output, 1 bit, meaning the current beat is the final beat of the frame.
REQ-012 Port busy, output, 1 bit, meaning the block is not in IDLE.
REQ-013 Port frame_cnt, output, 8 bits, meaning the number of frames sent, modulo 256.
REQ-014 Port size_err, output, 1 bit, meaning a one-cycle pulse when start is rejected for an illegal frame_size.

Function
REQ-015 FSM states: IDLE, HDR, DATA, GAP.
REQ-016 Start acceptance, legal frame_size: a multiple of 32 and 64..65504.
- start is accepted only in IDLE with a legal frame_size.
- On acceptance, the block latches frame_size and enters HDR.
REQ-017 Illegal start in IDLE: size_err pulses for 1 cycle and the block stays in IDLE.
REQ-018 Ignored starts: start in any state other than IDLE is ignored, with no error.
REQ-019 Header beat in HDR, tvalid=1.
- tdata[247:240]=frame_cnt, tdata[223:208]=latched size, tdata[191:128]=SYNC_WORD.
- All other bits 0.
REQ-020 Payload beats in DATA: frame_size/32+1 beats, numbered k=0..frame_size/32.
- Each 32-bit lane j (0..7) carries {frame_cnt, k[15:0], j[7:0]} in bits [32j+31:32j].
REQ-021 Frame length: total beats per frame = frame_size/32 + 2.
REQ-022 tlast: 1 only on the final DATA beat.
REQ-023 Handshake, AXI4-Stream:
- A beat transfers when tvalid and tready are both 1.
- tvalid, tdata and tlast hold stable until the transfer.
- tvalid never deasserts without a transfer.
REQ-024 Throughput: one beat per cycle while tready=1, with no bubbles from HDR to DATA or between DATA beats.
REQ-025 Beat counter: 16 bits; it advances only on a transfer.
REQ-026 Final transfer: on the tlast transfer, frame_cnt increments (255 wraps to 0) and the FSM enters GAP.
REQ-027 GAP: lasts exactly GAP_MIN cycles with tvalid=0, then returns to IDLE.
- A start arriving in GAP is ignored.
REQ-028 Outputs are registered; the first beat appears 1 cycle after start acceptance.
REQ-029 tready=0 during GAP or IDLE has no effect.

Reset
REQ-030 While rst=1, all outputs are 0 and the FSM is in IDLE; frame_cnt=0 and the beat counter=0.
REQ-031 Reset mid-frame abandons the frame immediately, with no tlast; after release the block is in IDLE and a new start sends frame_cnt=0.

Structure
REQ-032 A shared package holds: SYNC_WORD, the FSM state encoding, the header bit-field positions (frame_cnt 247:240, size 223:208, sync 191:128) and the size limits.
- The same package is used by the receive side.
REQ-033 Sub-module: payload pattern generator frame_pattern_gen (combinational, from frame_cnt and k); the FSM and counters live in the top module.

Verification
REQ-034 Scenario 1: frame_size=64, tready=1, start.
- Required: 4 beats, header with size 16'h0040 and cnt 0, then payload k=0..2, tlast on beat 4.
- Afterwards: frame_cnt=1 and 4 idle cycles.
REQ-035 Scenario 2: frame_size=96, tready toggling 1/0 every cycle.
- Required: 5 beats, each held stable while tready=0, tlast only on beat 5.
REQ-036 Scenario 3: frame_size=100, start.
- Required: size_err pulses 1 cycle, no tvalid, busy stays 0.
REQ-037 Scenario 4: send 257 frames of 64 bytes.
- Required: the 257th header carries frame_cnt 8'h00 and frame_cnt ends at 1.
REQ-038 Scenario 5: rst asserted on the 3rd payload beat of a 128-byte frame.
- Required: tvalid=0 asynchronously.
- The next start produces a header with cnt 0.
REQ-039 Scenario 6: start held high continuously, frame_size=64.
- Required: back-to-back frames separated by exactly 4 tvalid=0 cycles plus 1 IDLE cycle.
